// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution stage: kernel modes, fixed kernels and accumulator sizing.
package conv_pkg;

   // Kernel select values carried on the mode input
   localparam logic [1:0] MODE_BYPASS = 2'd0;
   localparam logic [1:0] MODE_GAUSS  = 2'd1;
   localparam logic [1:0] MODE_SHARP  = 2'd2;
   localparam logic [1:0] MODE_PROG   = 2'd3;

   // Row-major 3x3 kernels, element 0 is k00
   typedef int kern_t [9];

   localparam kern_t      KERN_BYPASS  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
   localparam logic [3:0] SHIFT_BYPASS = 4'd0;
   localparam kern_t      KERN_GAUSS   = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
   localparam logic [3:0] SHIFT_GAUSS  = 4'd4;
   localparam kern_t      KERN_SHARP   = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
   localparam logic [3:0] SHIFT_SHARP  = 4'd0;

   // Signed accumulator width: product plus growth for nine taps and the rounding bias
   function automatic int unsigned acc_w(input int unsigned pix_w, input int unsigned coef_w);
      return pix_w + coef_w + 5;
   endfunction

endpackage

// File: rtl/conv3x3_filter_if.sv
// Window-in / pixel-out stream bundle for conv3x3_filter.
//   mode, coef, shift, pixels_in, in_valid : window beat and its kernel settings (master -> slave)
//   in_ready                               : window accepted on in_valid && in_ready (slave -> master)
//   out, out_sat, out_valid                : filtered pixel and clamp flag (slave -> master)
//   out_ready                              : downstream accepts on out_valid && out_ready (master -> slave)
interface conv3x3_filter_if #(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned COEF_W = 5
) ();
   logic [1:0]          mode;
   logic [9*COEF_W-1:0] coef;
   logic [3:0]          shift;
   logic                in_valid;
   logic                in_ready;
   logic [9*PIX_W-1:0]  pixels_in;
   logic                out_valid;
   logic                out_ready;
   logic [PIX_W-1:0]    out;
   logic                out_sat;

   modport master (
      output mode, coef, shift, in_valid, pixels_in, out_ready,
      input  in_ready, out_valid, out, out_sat
   );

   modport slave (
      input  mode, coef, shift, in_valid, pixels_in, out_ready,
      output in_ready, out_valid, out, out_sat
   );
endinterface

// File: rtl/conv_row_mac.sv
// Combinational 3-tap signed multiply-add for one kernel row.
//   pix  : three unsigned pixels, tap 0 at MSBs (zero-extended before multiply)
//   coef : three signed coefficients, tap 0 at MSBs
//   sum  : signed row sum, ACC_W bits
module conv_row_mac #(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned COEF_W = 5,
   parameter int unsigned ACC_W  = 18
) (
   input  logic [3*PIX_W-1:0]      pix,
   input  logic [3*COEF_W-1:0]     coef,
   output logic signed [ACC_W-1:0] sum
);

   logic signed [ACC_W-1:0] prod [3];

   for (genvar i = 0; i < 3; i++) begin : g_tap
      logic signed [ACC_W-1:0] p_ext;
      logic signed [ACC_W-1:0] c_ext;
      assign p_ext   = ACC_W'(pix[(2-i)*PIX_W +: PIX_W]);
      assign c_ext   = ACC_W'($signed(coef[(2-i)*COEF_W +: COEF_W]));
      assign prod[i] = p_ext * c_ext;
   end

   assign sum = prod[0] + prod[1] + prod[2];

endmodule

// File: rtl/conv3x3_filter.sv
// Pipelined 3x3 convolution with per-window kernel mode, rounding, saturation and backpressure.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : window stream in, filtered pixel stream out (see conv3x3_filter_if)
// Registers: S0 window+kernel, S1 row sums, S2 total, S3 rounded/shifted value, then the
// clamped output register; a window accepted at edge N is presented at edge N+4.
module conv3x3_filter
   import conv_pkg::*;
#(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned COEF_W = 5,
   parameter int unsigned ROUND  = 1
) (
   input logic             clk,
   input logic             rst,
   conv3x3_filter_if.slave bus
);

   localparam int unsigned ACC_W = acc_w(PIX_W, COEF_W);
   localparam int unsigned PW    = 9 * PIX_W;
   localparam int unsigned KW    = 9 * COEF_W;
   localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((2 ** PIX_W) - 1);

   function automatic logic [KW-1:0] pack_kern(input kern_t k);
      logic [KW-1:0] r;
      r = '0;
      for (int i = 0; i < 9; i++) r[(8-i)*COEF_W +: COEF_W] = COEF_W'(k[i]);
      return r;
   endfunction

   logic                    adv;
   logic                    s0_v, s1_v, s2_v, s3_v;
   logic [PW-1:0]           s0_pix;
   logic [KW-1:0]           s0_coef;
   logic [3:0]              s0_shift, s1_shift, s2_shift;
   logic signed [ACC_W-1:0] row_c [3];
   logic signed [ACC_W-1:0] s1_row [3];
   logic signed [ACC_W-1:0] s2_sum, s3_val, biased_c, shifted_c;
   logic [KW-1:0]           kern_c;
   logic [3:0]              shift_c;
   logic [PIX_W-1:0]        out_c;
   logic                    sat_c;

   // Whole pipeline moves together; it can only stall when the output is held
   assign adv          = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv;

   // Resolve the kernel at capture so each beat carries its own settings
   always_comb begin
      kern_c  = pack_kern(KERN_BYPASS);
      shift_c = SHIFT_BYPASS;
      case (bus.mode)
         MODE_GAUSS: begin kern_c = pack_kern(KERN_GAUSS); shift_c = SHIFT_GAUSS; end
         MODE_SHARP: begin kern_c = pack_kern(KERN_SHARP); shift_c = SHIFT_SHARP; end
         MODE_PROG:  begin kern_c = bus.coef;              shift_c = bus.shift;   end
         default:    ;
      endcase
   end

   for (genvar r = 0; r < 3; r++) begin : g_row
      conv_row_mac #(.PIX_W(PIX_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
         .pix  (s0_pix[(2-r)*3*PIX_W +: 3*PIX_W]),
         .coef (s0_coef[(2-r)*3*COEF_W +: 3*COEF_W]),
         .sum  (row_c[r])
      );
   end

   // Round-half-up bias then arithmetic shift
   always_comb begin
      biased_c = s2_sum;
      if (ROUND != 0 && s2_shift != 4'd0)
         biased_c = s2_sum + (ACC_W'(1) << (s2_shift - 4'd1));
      shifted_c = biased_c >>> s2_shift;
   end

   // Clamp to the unsigned pixel range
   always_comb begin
      out_c = s3_val[PIX_W-1:0];
      sat_c = 1'b0;
      if (s3_val[ACC_W-1]) begin
         out_c = '0;
         sat_c = 1'b1;
      end else if (s3_val > PIX_MAX) begin
         out_c = '1;
         sat_c = 1'b1;
      end
   end

   // Stage registers and valid chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_v          <= 1'b0;
         s1_v          <= 1'b0;
         s2_v          <= 1'b0;
         s3_v          <= 1'b0;
         s0_pix        <= '0;
         s0_coef       <= '0;
         s0_shift      <= '0;
         s1_shift      <= '0;
         s2_shift      <= '0;
         s1_row        <= '{default: '0};
         s2_sum        <= '0;
         s3_val        <= '0;
         bus.out_valid <= 1'b0;
         bus.out       <= '0;
         bus.out_sat   <= 1'b0;
      end else if (adv) begin
         s0_v <= bus.in_valid;
         if (bus.in_valid) begin
            s0_pix   <= bus.pixels_in;
            s0_coef  <= kern_c;
            s0_shift <= shift_c;
         end
         s1_v          <= s0_v;
         s1_row        <= row_c;
         s1_shift      <= s0_shift;
         s2_v          <= s1_v;
         s2_sum        <= s1_row[0] + s1_row[1] + s1_row[2];
         s2_shift      <= s1_shift;
         s3_v          <= s2_v;
         s3_val        <= shifted_c;
         bus.out_valid <= s3_v;
         bus.out       <= out_c;
         bus.out_sat   <= sat_c;
      end
   end

endmodule

// File: tb/tb_conv3x3_filter.sv
// Self-checking bench for conv3x3_filter: a rounding instance and a truncating instance share
// one stimulus stream; an integer reference model predicts every delivered pixel.
module tb_conv3x3_filter;
   import conv_pkg::*;

   localparam int unsigned PIX_W  = 8;
   localparam int unsigned COEF_W = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   conv3x3_filter_if #(.PIX_W(PIX_W), .COEF_W(COEF_W)) bus0 ();
   conv3x3_filter_if #(.PIX_W(PIX_W), .COEF_W(COEF_W)) bus1 ();

   assign bus1.mode      = bus0.mode;
   assign bus1.coef      = bus0.coef;
   assign bus1.shift     = bus0.shift;
   assign bus1.in_valid  = bus0.in_valid;
   assign bus1.pixels_in = bus0.pixels_in;
   assign bus1.out_ready = bus0.out_ready;

   conv3x3_filter #(.PIX_W(PIX_W), .COEF_W(COEF_W), .ROUND(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   conv3x3_filter #(.PIX_W(PIX_W), .COEF_W(COEF_W), .ROUND(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int         errors = 0;
   int         checks = 0;
   int         delivered = 0;
   int         stall_cnt = 0;
   logic [8:0] q0 [$];
   logic [8:0] q1 [$];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_out;
   logic       prev_sat;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain integer convolution, {sat, pixel}
   function automatic logic [8:0] model(input logic [1:0] m, input logic [44:0] cf,
                                        input logic [3:0] sh, input logic [71:0] px, input bit rnd);
      int k [9];
      int s;
      int acc;
      logic signed [4:0] c;
      case (m)
         2'd0:    begin k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};     s = 0; end
         2'd1:    begin k = '{1, 2, 1, 2, 4, 2, 1, 2, 1};     s = 4; end
         2'd2:    begin k = '{0, -1, 0, -1, 5, -1, 0, -1, 0}; s = 0; end
         default: begin
            for (int i = 0; i < 9; i++) begin
               c    = cf[(8-i)*5 +: 5];
               k[i] = int'(c);
            end
            s = int'(sh);
         end
      endcase
      acc = 0;
      for (int i = 0; i < 9; i++) acc += k[i] * int'(px[(8-i)*8 +: 8]);
      if (rnd && s > 0) acc += 1 << (s - 1);
      acc = acc >>> s;
      if (acc < 0)   return {1'b1, 8'd0};
      if (acc > 255) return {1'b1, 8'd255};
      return {1'b0, 8'(acc)};
   endfunction

   function automatic logic [71:0] win_c(input int ctr, input int oth);
      logic [7:0] cv;
      logic [7:0] ov;
      cv = 8'(ctr);
      ov = 8'(oth);
      return {ov, ov, ov, ov, cv, ov, ov, ov, ov};
   endfunction

   // Present one window from posedge+1, hold until accepted, return at posedge+1
   task automatic put(input logic [1:0] m, input logic [44:0] cf, input logic [3:0] sh,
                      input logic [71:0] px);
      int n;
      bit acc;
      bus0.mode      = m;
      bus0.coef      = cf;
      bus0.shift     = sh;
      bus0.pixels_in = px;
      bus0.in_valid  = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         acc = bus0.in_ready;
         n++;
      end while (!acc && n < 50);
      if (!acc) check("accept_timeout", 0, 1);
      #1;
      bus0.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!bus0.out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!bus0.out_valid) check("out_valid_timeout", 0, 1);
   endtask

   int cyc;
   int d_snap;
   int s_snap;

   initial begin
      rst            = 1'b1;
      bus0.mode      = 2'd0;
      bus0.coef      = '0;
      bus0.shift     = '0;
      bus0.pixels_in = '0;
      bus0.in_valid  = 1'b0;
      bus0.out_ready = 1'b1;

      fork
         // Scoreboard: enqueue predictions on accept, retire on output handshake
         forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
               q0.delete();
               q1.delete();
            end else begin
               if (bus0.out_valid && bus0.out_ready && q0.size() > 0) begin
                  q0.delete(0);
                  delivered++;
               end
               if (bus1.out_valid && bus1.out_ready && q1.size() > 0) q1.delete(0);
               if (bus0.in_valid && bus0.in_ready) begin
                  q0.push_back(model(bus0.mode, bus0.coef, bus0.shift, bus0.pixels_in, 1'b1));
                  q1.push_back(model(bus0.mode, bus0.coef, bus0.shift, bus0.pixels_in, 1'b0));
               end
            end
         end
         // Per-cycle output checks, sampled on the falling edge
         forever begin
            @(negedge clk);
            if (rst) begin
               prev_stall = 1'b0;
            end else begin
               check("in_ready_rule", int'(bus0.in_ready), int'(!bus0.out_valid || bus0.out_ready));
               if (prev_stall) begin
                  check("stall_hold_valid", int'(bus0.out_valid), 1);
                  check("stall_hold_out", int'(bus0.out), int'(prev_out));
                  check("stall_hold_sat", int'(bus0.out_sat), int'(prev_sat));
               end
               if (bus0.out_valid) begin
                  if (q0.size() == 0) check("spurious_out_r1", 1, 0);
                  else begin
                     check("model_out_r1", int'(bus0.out), int'(q0[0][7:0]));
                     check("model_sat_r1", int'(bus0.out_sat), int'(q0[0][8]));
                  end
               end
               if (bus1.out_valid) begin
                  if (q1.size() == 0) check("spurious_out_r0", 1, 0);
                  else begin
                     check("model_out_r0", int'(bus1.out), int'(q1[0][7:0]));
                     check("model_sat_r0", int'(bus1.out_sat), int'(q1[0][8]));
                  end
               end
               prev_stall = bus0.out_valid && !bus0.out_ready;
               prev_out   = bus0.out;
               prev_sat   = bus0.out_sat;
               if (prev_stall) stall_cnt++;
            end
         end
      join_none

      // Reset state
      #12;
      check("reset_out_valid", int'(bus0.out_valid), 0);
      check("reset_out", int'(bus0.out), 0);
      check("reset_out_sat", int'(bus0.out_sat), 0);
      bus0.out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("in_ready_after_release", int'(bus0.in_ready), 1);
      bus0.out_ready = 1'b1;

      // Undriven window data with in_valid low must not create output
      bus0.pixels_in = 'x;
      bus0.coef      = 'x;
      repeat (6) @(posedge clk);
      #1;
      check("x_idle_no_valid", int'(bus0.out_valid), 0);

      // 1: Gaussian flat field, latency
      put(MODE_GAUSS, '0, '0, win_c(100, 100));
      wait_out(cyc);
      check("t1_latency", cyc, 4);
      check("t1_out", int'(bus0.out), 100);
      check("t1_sat", int'(bus0.out_sat), 0);

      // 2: Gaussian impulse, rounding vs truncation
      put(MODE_GAUSS, '0, '0, win_c(255, 0));
      wait_out(cyc);
      check("t2_out_round", int'(bus0.out), 64);
      check("t2_out_trunc", int'(bus1.out), 63);

      // 3: Sharpen saturation both ways
      put(MODE_SHARP, '0, '0, win_c(200, 10));
      wait_out(cyc);
      check("t3_hi_out", int'(bus0.out), 255);
      check("t3_hi_sat", int'(bus0.out_sat), 1);
      put(MODE_SHARP, '0, '0, win_c(10, 200));
      wait_out(cyc);
      check("t3_lo_out", int'(bus0.out), 0);
      check("t3_lo_sat", int'(bus0.out_sat), 1);

      // 4: Programmable then bypass back to back
      put(MODE_PROG, {9{5'd1}}, 4'd3, win_c(8, 8));
      put(MODE_BYPASS, '0, '0, win_c(77, 0));
      wait_out(cyc);
      check("t4_prog_out", int'(bus0.out), 9);
      check("t4_prog_out_trunc", int'(bus1.out), 9);
      @(posedge clk);
      #1;
      check("t4_bypass_valid", int'(bus0.out_valid), 1);
      check("t4_bypass_out", int'(bus0.out), 77);
      repeat (2) @(posedge clk);
      #1;

      // 5: Stream of 8 with a 3-cycle downstream stall
      d_snap = delivered;
      s_snap = stall_cnt;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               if (i % 2 == 0) put(MODE_BYPASS, '0, '0, win_c(i * 30 + 7, 255));
               else            put(MODE_GAUSS, '0, '0, win_c(i * 20, i * 20));
            end
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            bus0.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            bus0.out_ready = 1'b1;
         end
      join
      repeat (12) @(posedge clk);
      #1;
      check("t5_delivered", delivered - d_snap, 8);
      check("t5_stall_cycles", stall_cnt - s_snap, 3);
      check("t5_queue_empty", q0.size(), 0);

      // 6: Asynchronous reset with windows in flight
      for (int k = 1; k <= 4; k++) put(MODE_BYPASS, '0, '0, win_c(k, 0));
      @(posedge clk);
      #3;
      check("t6_valid_before_reset", int'(bus0.out_valid), 1);
      rst = 1'b1;
      #1;
      check("t6_reset_valid_r1", int'(bus0.out_valid), 0);
      check("t6_reset_valid_r0", int'(bus1.out_valid), 0);
      check("t6_reset_out", int'(bus0.out), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      put(MODE_GAUSS, '0, '0, win_c(50, 50));
      wait_out(cyc);
      check("t6_first_latency", cyc, 4);
      check("t6_first_out", int'(bus0.out), 50);
      repeat (3) @(posedge clk);
      #1;
      check("t6_no_stale_valid", int'(bus0.out_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
